// File: rtl/reset_release_sequencer_pkg.sv
// Shared types for the staged reset-release sequencer: FSM state encoding and timer sizing.
package reset_release_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } rrs_state_e;

  // Wide enough to hold the largest terminal count of any phase.
  function automatic int rrs_timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable down-counter that sticks at zero; expired flags the terminal count.
module reset_seq_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/reset_release_sequencer.sv
// Holds all reset domains low for a minimum width, then releases them one by one,
// waiting for each domain's ready with a per-domain timeout.
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS        = 4,
  parameter int MIN_ASSERT_CYCLES  = 16,
  parameter int STAGE_GAP_CYCLES   = 8,
  parameter int ACK_TIMEOUT_CYCLES = 64,
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   busy,
  output logic                   all_ready,
  output logic                   timeout_err,
  output logic [IW-1:0]          err_domain
);

  localparam int TW = rrs_timer_width(MIN_ASSERT_CYCLES, STAGE_GAP_CYCLES, ACK_TIMEOUT_CYCLES);

  // Loads are terminal-count minus one: the edge that sees zero is the last one of the phase.
  localparam logic [TW-1:0]          LD_ASSERT  = TW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [TW-1:0]          LD_GAP     = TW'(STAGE_GAP_CYCLES - 1);
  localparam logic [TW-1:0]          LD_TIMEOUT = TW'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]          LAST_IDX   = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] FIRST_REL  = NUM_DOMAINS'(1);

  rrs_state_e             state, state_n;
  logic [IW-1:0]          idx, idx_n;
  logic [IW-1:0]          err_domain_n;
  logic [NUM_DOMAINS-1:0] rel, rel_n;
  logic                   terr, terr_n;
  logic                   load;
  logic [TW-1:0]          load_val;
  logic                   expired;

  reset_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_ASSERT;
      idx        <= '0;
      rel        <= '0;
      terr       <= 1'b0;
      err_domain <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      rel        <= rel_n;
      terr       <= terr_n;
      err_domain <= err_domain_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    rel_n        = rel;
    terr_n       = terr;
    err_domain_n = err_domain;
    load         = 1'b0;
    load_val     = '0;

    if (!reset_n || sw_reset_req) begin
      state_n      = ST_ASSERT;
      idx_n        = '0;
      rel_n        = '0;
      terr_n       = 1'b0;
      err_domain_n = '0;
      load         = 1'b1;
      load_val     = LD_ASSERT;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (expired) begin
            rel_n    = FIRST_REL;
            state_n  = ST_WAIT_ACK;
            load     = 1'b1;
            load_val = LD_TIMEOUT;
          end
        end
        ST_RELEASE: begin
          state_n  = ST_WAIT_ACK;
          load     = 1'b1;
          load_val = LD_TIMEOUT;
        end
        ST_WAIT_ACK: begin
          if (domain_ready[idx]) begin
            if (idx == LAST_IDX) begin
              state_n = ST_DONE;
            end else begin
              state_n  = ST_GAP;
              load     = 1'b1;
              load_val = LD_GAP;
            end
          end else if (expired) begin
            state_n      = ST_ERROR;
            rel_n        = '0;
            terr_n       = 1'b1;
            err_domain_n = idx;
          end
        end
        ST_GAP: begin
          if (expired) begin
            // Shifting a one in keeps the released set contiguous from bit 0.
            idx_n    = idx + IW'(1);
            rel_n    = (rel << 1) | FIRST_REL;
            state_n  = ST_WAIT_ACK;
            load     = 1'b1;
            load_val = LD_TIMEOUT;
          end
        end
        ST_DONE:  state_n = ST_DONE;
        ST_ERROR: state_n = ST_ERROR;
        default:  state_n = ST_ERROR;
      endcase
    end
  end

  assign domain_reset_n = rel;
  assign timeout_err    = terr;
  assign busy           = (state == ST_ASSERT) || (state == ST_RELEASE) ||
                          (state == ST_WAIT_ACK) || (state == ST_GAP);
  assign all_ready      = (state == ST_DONE);

endmodule
